// File: rtl/flash_sram_loader.sv
// flash_sram_loader: copies 32-bit words from 16-bit NOR flash into async SRAM.
// Each word is two halfword reads, then a setup / pulse / hold write cycle.
module flash_sram_loader #(
   parameter int FLASH_ADDR_W   = 23,
   parameter int SRAM_ADDR_W    = 20,
   parameter int LEN_W          = 20,
   parameter int FLASH_WAIT     = 8,
   parameter int SRAM_WE_CYCLES = 2,
   parameter bit REVERSE_ENDIAN = 1'b0
) (
   input  logic                    clk_50M,
   input  logic                    reset_btn,
   input  logic                    start,
   input  logic [FLASH_ADDR_W-1:0] src_addr,
   input  logic [SRAM_ADDR_W-1:0]  dst_addr,
   input  logic [LEN_W-1:0]        len_words,
   output logic                    busy,
   output logic                    done,
   output logic [LEN_W-1:0]        words_done,
   output logic [FLASH_ADDR_W-1:0] flash_a,
   input  logic [15:0]             flash_d_i,
   output logic                    flash_ce_n,
   output logic                    flash_oe_n,
   output logic [SRAM_ADDR_W-1:0]  sram_addr,
   output logic [31:0]             sram_data_o,
   output logic                    sram_data_oe,
   output logic                    sram_ce_n,
   output logic                    sram_oe_n,
   output logic                    sram_we_n,
   output logic [3:0]              sram_be_n
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RD_LO    = 3'd1;
   localparam logic [2:0] S_RD_HI    = 3'd2;
   localparam logic [2:0] S_WR_SETUP = 3'd3;
   localparam logic [2:0] S_WR_PULSE = 3'd4;
   localparam logic [2:0] S_WR_HOLD  = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   localparam logic [15:0] RD_LAST = 16'(FLASH_WAIT - 1);
   localparam logic [15:0] WE_LAST = 16'(SRAM_WE_CYCLES - 1);
   localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   logic [2:0]              state;
   logic [15:0]             cnt;
   logic [FLASH_ADDR_W-1:0] src;
   logic [SRAM_ADDR_W-1:0]  dst;
   logic [LEN_W-1:0]        len;
   logic [LEN_W-1:0]        idx;
   logic [LEN_W-1:0]        idx_nx;
   logic [15:0]             lo;
   logic [15:0]             hi;
   logic [31:0]             word;
   logic [LEN_W+1:0]        idx_b;
   logic [FLASH_ADDR_W-1:0] fl_base;

   assign idx_nx  = idx + ONE;
   assign idx_b   = {idx, 2'b00};
   assign fl_base = src + FLASH_ADDR_W'(idx_b);

   // Optional byte swap of the assembled {hi, lo} word
   always_comb begin
      word = {hi, lo};
      if (REVERSE_ENDIAN)
         word = {hi[7:0], hi[15:8], lo[7:0], lo[15:8]};
      word = REVERSE_ENDIAN ? {lo[7:0], lo[15:8], hi[7:0], hi[15:8]} : {hi, lo};
   end

   // Transfer sequencer: read two halfwords, then one timed SRAM write
   always_ff @(posedge clk_50M) begin
      if (reset_btn) begin
         state <= S_IDLE;
         cnt   <= '0;
         src   <= '0;
         dst   <= '0;
         len   <= '0;
         idx   <= '0;
         lo    <= '0;
         hi    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  src   <= {src_addr[FLASH_ADDR_W-1:2], 2'b00};
                  dst   <= dst_addr;
                  len   <= len_words;
                  idx   <= '0;
                  cnt   <= '0;
                  state <= (len_words == '0) ? S_DONE : S_RD_LO;
               end
            end
            S_RD_LO: begin
               if (cnt == RD_LAST) begin
                  lo    <= flash_d_i;
                  cnt   <= '0;
                  state <= S_RD_HI;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_RD_HI: begin
               if (cnt == RD_LAST) begin
                  hi    <= flash_d_i;
                  cnt   <= '0;
                  state <= S_WR_SETUP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_WR_SETUP: begin
               cnt   <= '0;
               state <= S_WR_PULSE;
            end
            S_WR_PULSE: begin
               if (cnt == WE_LAST) begin
                  cnt   <= '0;
                  state <= S_WR_HOLD;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_WR_HOLD: begin
               idx   <= idx_nx;
               state <= (idx_nx == len) ? S_DONE : S_RD_LO;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Pin drive decoded from state; idle and done release every bus
   always_comb begin
      busy         = 1'b0;
      done         = 1'b0;
      flash_a      = '0;
      flash_ce_n   = 1'b1;
      flash_oe_n   = 1'b1;
      sram_addr    = '0;
      sram_data_o  = '0;
      sram_data_oe = 1'b0;
      sram_ce_n    = 1'b1;
      sram_oe_n    = 1'b1;
      sram_we_n    = 1'b1;
      sram_be_n    = 4'hF;
      case (state)
         S_RD_LO, S_RD_HI: begin
            busy       = 1'b1;
            flash_ce_n = 1'b0;
            flash_oe_n = 1'b0;
            flash_a    = (state == S_RD_HI) ?
                         fl_base + FLASH_ADDR_W'(2) : fl_base;
         end
         S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
            busy         = 1'b1;
            sram_addr    = dst + SRAM_ADDR_W'(idx);
            sram_data_o  = word;
            sram_data_oe = 1'b1;
            sram_ce_n    = 1'b0;
            sram_be_n    = 4'h0;
            sram_we_n    = (state != S_WR_PULSE);
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign words_done = idx;

endmodule
